wb_arbiter: RTL and testbench

Writeback arbiter between the integer pipeline and the quantum measurement unit, feeding the single write port of the register file (`we`/`rd`/`wd`). The integer pipeline writes back every cycle it can. Measurement results arrive late and out of band, so they are buffered in a small FIFO and merged into idle write slots. A per-register pending bitmap tells decode which destinations still await a measurement result.

---
 rtl/rv_pkg.sv | 18 +
 rtl/wb_fifo.sv | 68 ++++++
 rtl/wb_arbiter.sv | 134 +++++++++++++
 tb/tb_wb_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared types for the writeback path: request payload and arbitration select.
package rv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] wd;
    } wb_req_t;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_PIPE,
        WB_QFIFO
    } wb_sel_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback requests. Push while full is accepted only
// when a pop happens in the same cycle, so occupancy stays constant.
module wb_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  wb_req_t       push_data,
    input  logic          pop,
    output wb_req_t       head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    wb_req_t       mem_q [DEPTH];
    wb_req_t       mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && (!full || pop);
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // Power-of-two depth: pointers wrap naturally in AW bits.
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges buffered measurement results into register-file
// write slots left idle by the integer pipeline, and tracks pending results.
module wb_arbiter
    import rv_pkg::*;
#(
    parameter int QDEPTH = 4,
    parameter int XLEN   = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pipe_we,
    input  logic [4:0]      pipe_rd,
    input  logic [XLEN-1:0] pipe_wd,
    output logic            pipe_ready,
    input  logic            q_valid,
    input  logic [4:0]      q_rd,
    input  logic [XLEN-1:0] q_wd,
    output logic            q_ready,
    input  logic            q_issue,
    input  logic [4:0]      q_issue_rd,
    output logic [31:0]     busy,
    output logic            rf_we,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_wd
);

    localparam int CW = $clog2(QDEPTH) + 1;

    wb_req_t         q_req;
    wb_req_t         fifo_head;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    wb_sel_e         sel;

    logic [31:0]     busy_q, busy_d;
    logic            rf_we_q, rf_we_d;
    logic [4:0]      rf_rd_q, rf_rd_d;
    logic [XLEN-1:0] rf_wd_q, rf_wd_d;

    // Handshakes: a transfer happens on an edge where valid (pipe_we/q_valid)
    // and ready are both high; ready depends only on FIFO occupancy, and a
    // producer seeing ready low holds its request unchanged.
    assign q_ready    = !fifo_full;
    assign pipe_ready = !fifo_full;

    assign q_req.rd  = q_rd;
    assign q_req.wd  = q_wd;
    assign fifo_push = q_valid && q_ready && (q_rd != 5'd0);
    assign fifo_pop  = (sel == WB_QFIFO);

    wb_fifo #(
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (q_req),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        sel = WB_NONE;
        if (fifo_full) begin
            sel = WB_QFIFO;
        end else if (pipe_we) begin
            sel = WB_PIPE;
        end else if (!fifo_empty) begin
            sel = WB_QFIFO;
        end
    end

    always_comb begin
        rf_we_d = 1'b0;
        rf_rd_d = rf_rd_q;
        rf_wd_d = rf_wd_q;
        busy_d  = busy_q;
        case (sel)
            WB_PIPE: begin
                // An x0 write still takes the slot but never reaches the file.
                rf_we_d = (pipe_rd != 5'd0);
                rf_rd_d = pipe_rd;
                rf_wd_d = pipe_wd;
            end
            WB_QFIFO: begin
                rf_we_d = 1'b1;
                rf_rd_d = fifo_head.rd;
                rf_wd_d = fifo_head.wd;
                busy_d[fifo_head.rd] = 1'b0;
            end
            default: begin
                rf_we_d = 1'b0;
            end
        endcase
        // Applied after the clear so a same-edge issue keeps the bit set.
        if (q_issue && (q_issue_rd != 5'd0)) begin
            busy_d[q_issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q  <= '0;
            rf_we_q <= 1'b0;
            rf_rd_q <= '0;
            rf_wd_q <= '0;
        end else begin
            busy_q  <= busy_d;
            rf_we_q <= rf_we_d;
            rf_rd_q <= rf_rd_d;
            rf_wd_q <= rf_wd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (fifo_count <= CW'(QDEPTH));
            assert (fifo_full == (fifo_count == CW'(QDEPTH)));
        end
    end

    assign busy  = busy_q;
    assign rf_we = rf_we_q;
    assign rf_rd = rf_rd_q;
    assign rf_wd = rf_wd_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: each scenario task drives inputs and checks
// registered outputs one time unit after the rising edge.
module tb_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_wd;
    logic        pipe_ready;
    logic        q_valid;
    logic [4:0]  q_rd;
    logic [31:0] q_wd;
    logic        q_ready;
    logic        q_issue;
    logic [4:0]  q_issue_rd;
    logic [31:0] busy;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wd;

    int checks;
    int errors;

    wb_arbiter #(
        .QDEPTH (4),
        .XLEN   (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pipe_we    (pipe_we),
        .pipe_rd    (pipe_rd),
        .pipe_wd    (pipe_wd),
        .pipe_ready (pipe_ready),
        .q_valid    (q_valid),
        .q_rd       (q_rd),
        .q_wd       (q_wd),
        .q_ready    (q_ready),
        .q_issue    (q_issue),
        .q_issue_rd (q_issue_rd),
        .busy       (busy),
        .rf_we      (rf_we),
        .rf_rd      (rf_rd),
        .rf_wd      (rf_wd)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pipe_we    = 1'b0;
        pipe_rd    = '0;
        pipe_wd    = '0;
        q_valid    = 1'b0;
        q_rd       = '0;
        q_wd       = '0;
        q_issue    = 1'b0;
        q_issue_rd = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if (rf_we !== 1'b0) begin
            errors++; $display("FAIL reset_rf_we got %0b exp 0", rf_we);
        end
        checks++;
        if (busy !== 32'h0) begin
            errors++; $display("FAIL reset_busy got %h exp 0", busy);
        end
        checks++;
        if (rf_rd !== 5'd0 || rf_wd !== 32'h0) begin
            errors++; $display("FAIL reset_rf_data got rd=%0d wd=%h exp rd=0 wd=0", rf_rd, rf_wd);
        end
        checks++;
        if (q_ready !== 1'b1 || pipe_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got q=%0b p=%0b exp 1 1", q_ready, pipe_ready);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_pipe_only();
        pipe_we = 1'b1; pipe_rd = 5'd5; pipe_wd = 32'hDEADBEEF;
        checks++;
        if (pipe_ready !== 1'b1) begin
            errors++; $display("FAIL pipe_ready_pre got %0b exp 1", pipe_ready);
        end
        step();
        pipe_we = 1'b0;
        checks++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_wd !== 32'hDEADBEEF) begin
            errors++; $display("FAIL pipe_write got we=%0b rd=%0d wd=%h exp 1 5 deadbeef", rf_we, rf_rd, rf_wd);
        end
        checks++;
        if (pipe_ready !== 1'b1) begin
            errors++; $display("FAIL pipe_ready_post got %0b exp 1", pipe_ready);
        end
        step();
        checks++;
        if (rf_we !== 1'b0) begin
            errors++; $display("FAIL pipe_idle got we=%0b exp 0", rf_we);
        end
    endtask

    task automatic test_pending();
        q_issue = 1'b1; q_issue_rd = 5'd7;
        step();
        q_issue = 1'b0;
        checks++;
        if (busy !== 32'h0000_0080) begin
            errors++; $display("FAIL pend_set got %h exp 00000080", busy);
        end
        q_valid = 1'b1; q_rd = 5'd7; q_wd = 32'h1;
        step();
        q_valid = 1'b0;
        checks++;
        if (rf_we !== 1'b0 || busy !== 32'h0000_0080) begin
            errors++; $display("FAIL pend_push got we=%0b busy=%h exp 0 00000080", rf_we, busy);
        end
        step();
        checks++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd7 || rf_wd !== 32'h1) begin
            errors++; $display("FAIL pend_commit got we=%0b rd=%0d wd=%h exp 1 7 1", rf_we, rf_rd, rf_wd);
        end
        checks++;
        if (busy !== 32'h0) begin
            errors++; $display("FAIL pend_clear got %h exp 0", busy);
        end
    endtask

    task automatic test_contention();
        logic [4:0]  exp_rd [2];
        logic [31:0] exp_wd [2];
        exp_rd[0] = 5'd10; exp_wd[0] = 32'hA0;
        exp_rd[1] = 5'd11; exp_wd[1] = 32'hB0;
        q_issue = 1'b1; q_issue_rd = 5'd10;
        step();
        q_issue_rd = 5'd11;
        step();
        q_issue = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pipe_we = 1'b1; pipe_rd = 5'(i + 1); pipe_wd = 32'(100 + i);
            if (i < 2) begin
                q_valid = 1'b1; q_rd = exp_rd[i]; q_wd = exp_wd[i];
            end else begin
                q_valid = 1'b0;
            end
            step();
            checks++;
            if (rf_we !== 1'b1 || rf_rd !== 5'(i + 1) || rf_wd !== 32'(100 + i)) begin
                errors++; $display("FAIL cont_pipe%0d got we=%0b rd=%0d wd=%0d exp 1 %0d %0d", i, rf_we, rf_rd, rf_wd, i + 1, 100 + i);
            end
        end
        checks++;
        if (busy !== 32'h0000_0C00) begin
            errors++; $display("FAIL cont_busy got %h exp 00000c00", busy);
        end
        pipe_we = 1'b0; q_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (rf_we !== 1'b1 || rf_rd !== exp_rd[i] || rf_wd !== exp_wd[i]) begin
                errors++; $display("FAIL cont_drain%0d got we=%0b rd=%0d wd=%h exp 1 %0d %h", i, rf_we, rf_rd, rf_wd, exp_rd[i], exp_wd[i]);
            end
        end
        checks++;
        if (busy !== 32'h0) begin
            errors++; $display("FAIL cont_busy_clear got %h exp 0", busy);
        end
        step();
        checks++;
        if (rf_we !== 1'b0) begin
            errors++; $display("FAIL cont_idle got we=%0b exp 0", rf_we);
        end
    endtask

    task automatic test_full();
        pipe_we = 1'b1; pipe_rd = 5'd2; pipe_wd = 32'h22;
        for (int i = 0; i < 4; i++) begin
            q_valid = 1'b1; q_rd = 5'(12 + i); q_wd = 32'(32'hC0 + i);
            step();
            checks++;
            if (rf_we !== 1'b1 || rf_rd !== 5'd2 || rf_wd !== 32'h22) begin
                errors++; $display("FAIL full_fill%0d got we=%0b rd=%0d wd=%h exp 1 2 22", i, rf_we, rf_rd, rf_wd);
            end
        end
        q_valid = 1'b0;
        pipe_rd = 5'd3; pipe_wd = 32'h33;
        checks++;
        if (q_ready !== 1'b0 || pipe_ready !== 1'b0) begin
            errors++; $display("FAIL full_ready got q=%0b p=%0b exp 0 0", q_ready, pipe_ready);
        end
        step();
        checks++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd12 || rf_wd !== 32'hC0) begin
            errors++; $display("FAIL full_head got we=%0b rd=%0d wd=%h exp 1 12 c0", rf_we, rf_rd, rf_wd);
        end
        checks++;
        if (pipe_ready !== 1'b1 || q_ready !== 1'b1) begin
            errors++; $display("FAIL full_release got q=%0b p=%0b exp 1 1", q_ready, pipe_ready);
        end
        step();
        pipe_we = 1'b0;
        checks++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd3 || rf_wd !== 32'h33) begin
            errors++; $display("FAIL full_stalled got we=%0b rd=%0d wd=%h exp 1 3 33", rf_we, rf_rd, rf_wd);
        end
        for (int i = 1; i < 4; i++) begin
            step();
            checks++;
            if (rf_we !== 1'b1 || rf_rd !== 5'(12 + i) || rf_wd !== 32'(32'hC0 + i)) begin
                errors++; $display("FAIL full_drain%0d got we=%0b rd=%0d wd=%h exp 1 %0d %h", i, rf_we, rf_rd, rf_wd, 12 + i, 32'hC0 + i);
            end
        end
        step();
        checks++;
        if (rf_we !== 1'b0) begin
            errors++; $display("FAIL full_idle got we=%0b exp 0", rf_we);
        end
    endtask

    task automatic test_edges();
        q_issue = 1'b1; q_issue_rd = 5'd0;
        step();
        q_issue = 1'b0;
        checks++;
        if (busy !== 32'h0) begin
            errors++; $display("FAIL edge_issue_x0 got %h exp 0", busy);
        end
        q_valid = 1'b1; q_rd = 5'd0; q_wd = 32'h5;
        checks++;
        if (q_ready !== 1'b1) begin
            errors++; $display("FAIL edge_qx0_ready got %0b exp 1", q_ready);
        end
        step();
        q_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (rf_we !== 1'b0) begin
                errors++; $display("FAIL edge_qx0_we%0d got %0b exp 0", i, rf_we);
            end
        end
        pipe_we = 1'b1; pipe_rd = 5'd0; pipe_wd = 32'h77;
        step();
        pipe_we = 1'b0;
        checks++;
        if (rf_we !== 1'b0) begin
            errors++; $display("FAIL edge_pipe_x0 got we=%0b exp 0", rf_we);
        end
        q_issue = 1'b1; q_issue_rd = 5'd3;
        step();
        q_issue = 1'b0;
        q_valid = 1'b1; q_rd = 5'd3; q_wd = 32'h9;
        step();
        q_valid = 1'b0;
        q_issue = 1'b1; q_issue_rd = 5'd3;
        step();
        q_issue = 1'b0;
        checks++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd3 || rf_wd !== 32'h9) begin
            errors++; $display("FAIL edge_conflict_wr got we=%0b rd=%0d wd=%h exp 1 3 9", rf_we, rf_rd, rf_wd);
        end
        checks++;
        if (busy !== 32'h0000_0008) begin
            errors++; $display("FAIL edge_conflict_busy got %h exp 00000008", busy);
        end
    endtask

    task automatic test_reset_mid();
        q_issue = 1'b1; q_issue_rd = 5'd20;
        step();
        q_issue = 1'b0;
        pipe_we = 1'b1; pipe_rd = 5'd4; pipe_wd = 32'h44;
        for (int i = 0; i < 3; i++) begin
            q_valid = 1'b1; q_rd = 5'(20 + i); q_wd = 32'(32'hE0 + i);
            step();
        end
        idle_inputs();
        rst_n = 1'b0;
        step();
        checks++;
        if (rf_we !== 1'b0 || busy !== 32'h0 || q_ready !== 1'b1) begin
            errors++; $display("FAIL mid_reset got we=%0b busy=%h q_ready=%0b exp 0 0 1", rf_we, busy, q_ready);
        end
        checks++;
        if (rf_rd !== 5'd0 || rf_wd !== 32'h0) begin
            errors++; $display("FAIL mid_reset_data got rd=%0d wd=%h exp 0 0", rf_rd, rf_wd);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (rf_we !== 1'b0) begin
                errors++; $display("FAIL mid_reset_leak%0d got we=%0b rd=%0d exp we=0", i, rf_we, rf_rd);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle_inputs();
        test_reset();
        test_pipe_only();
        test_pending();
        test_contention();
        test_full();
        test_edges();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
